// File: rtl/fsm_sequence_gen.sv
// Serial bit-pattern generator: captures a pattern and shifts it out MSB-first, with optional gapped repeats.
// Latency: first pattern bit appears on the same edge that samples start_i; done_o ticks one cycle after the last bit.
// Backpressure: none; start_i is ignored while busy_o is high.
//
// Ports:
//   clk_i        rising-edge clock
//   reset_i      asynchronous active-low reset (0 = reset asserted)
//   start_i      frame request, sampled only in IDLE
//   pattern_i    bits to emit; bit [L-1] goes out first
//   length_i     bits per repetition; 0 or >WIDTH selects WIDTH
//   repeat_cnt_i extra repetitions after the first
//   gap_i        idle cycles between repetitions
//   sequence_o   serial data out (IDLE_BIT when not emitting)
//   valid_o      high while sequence_o carries a pattern bit
//   busy_o       high in every state except IDLE
//   done_o       one-cycle tick after the final bit of the frame
//   state_reg_o  current FSM state, for debug
module fsm_sequence_gen #(
  parameter int   WIDTH    = 8,
  parameter int   LEN_W    = 4,
  parameter logic IDLE_BIT = 1'b0
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             start_i,
  input  logic [WIDTH-1:0] pattern_i,
  input  logic [LEN_W-1:0] length_i,
  input  logic [3:0]       repeat_cnt_i,
  input  logic [3:0]       gap_i,
  output logic             sequence_o,
  output logic             valid_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [2:0]       state_reg_o
);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_SHIFT = 3'd1;
  localparam logic [2:0] ST_GAP   = 3'd2;
  localparam logic [2:0] ST_DONE  = 3'd3;

  localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [LEN_W-1:0] WIDTH_L = LEN_W'(WIDTH);

  logic [2:0]       state_q, state_d;
  logic [WIDTH-1:0] pat_q,   pat_d;
  logic [IDX_W-1:0] len_q,   len_d;   // shadow of L-1, the reload index
  logic [IDX_W-1:0] idx_q,   idx_d;
  logic [3:0]       rep_q,   rep_d;   // repetitions still to emit
  logic [3:0]       gap_q,   gap_d;
  logic [3:0]       gcnt_q,  gcnt_d;  // gap cycles left after the current one

  logic [LEN_W-1:0] len_eff;
  logic [IDX_W-1:0] len_m1;

  // Out-of-range lengths (0 or wider than the pattern) fall back to the full width.
  always_comb begin
    len_eff = length_i;
    if (length_i == '0 || length_i > WIDTH_L) begin
      len_eff = WIDTH_L;
    end
    len_m1 = IDX_W'(len_eff - LEN_W'(1));
  end

  always_comb begin
    state_d = state_q;
    pat_d   = pat_q;
    len_d   = len_q;
    idx_d   = idx_q;
    rep_d   = rep_q;
    gap_d   = gap_q;
    gcnt_d  = gcnt_q;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          pat_d   = pattern_i;
          len_d   = len_m1;
          idx_d   = len_m1;
          rep_d   = repeat_cnt_i;
          gap_d   = gap_i;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (idx_q != '0) begin
          idx_d = idx_q - IDX_W'(1);
        end else if (rep_q != 4'd0) begin
          if (gap_q != 4'd0) begin
            gcnt_d  = gap_q - 4'd1;
            state_d = ST_GAP;
          end else begin
            // Back-to-back repetition: reload without a bubble.
            idx_d = len_q;
            rep_d = rep_q - 4'd1;
          end
        end else begin
          state_d = ST_DONE;
        end
      end
      ST_GAP: begin
        if (gcnt_q == 4'd0) begin
          idx_d   = len_q;
          rep_d   = rep_q - 4'd1;
          state_d = ST_SHIFT;
        end else begin
          gcnt_d = gcnt_q - 4'd1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;  // unused codes recover in one clock
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q <= ST_IDLE;
      pat_q   <= '0;
      len_q   <= '0;
      idx_q   <= '0;
      rep_q   <= '0;
      gap_q   <= '0;
      gcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      pat_q   <= pat_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      rep_q   <= rep_d;
      gap_q   <= gap_d;
      gcnt_q  <= gcnt_d;
    end
  end

  // Outputs decode registered state only, so reset reaches them without a clock.
  assign valid_o     = (state_q == ST_SHIFT);
  assign sequence_o  = valid_o ? pat_q[idx_q] : IDLE_BIT;
  assign busy_o      = (state_q != ST_IDLE);
  assign done_o      = (state_q == ST_DONE);
  assign state_reg_o = state_q;

endmodule

// File: tb/tb_fsm_sequence_gen.sv
module tb_fsm_sequence_gen;

  logic       clk_i;
  logic       reset_i;
  logic       start_i;
  logic [7:0] pattern_i;
  logic [3:0] length_i;
  logic [3:0] repeat_cnt_i;
  logic [3:0] gap_i;
  logic       sequence_o;
  logic       valid_o;
  logic       busy_o;
  logic       done_o;
  logic [2:0] state_reg_o;

  int n_checks = 0;
  int n_pass   = 0;

  fsm_sequence_gen #(.WIDTH(8), .LEN_W(4), .IDLE_BIT(1'b0)) dut (
    .clk_i        (clk_i),
    .reset_i      (reset_i),
    .start_i      (start_i),
    .pattern_i    (pattern_i),
    .length_i     (length_i),
    .repeat_cnt_i (repeat_cnt_i),
    .gap_i        (gap_i),
    .sequence_o   (sequence_o),
    .valid_o      (valid_o),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .state_reg_o  (state_reg_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Observed outputs packed as {state, busy, done, valid, sequence}.
  function automatic logic [31:0] obs();
    return 32'({state_reg_o, busy_o, done_o, valid_o, sequence_o});
  endfunction

  // Expected vector for frame cycle i of n; seqv/valv hold the hand-written
  // streams with cycle 0 at bit n-1. The last cycle is the DONE tick.
  function automatic logic [31:0] exp_vec(int i, int n, logic [63:0] seqv, logic [63:0] valv);
    logic [2:0] st;
    logic       dn;
    dn = (i == n - 1);
    st = dn ? 3'd3 : (valv[n-1-i] ? 3'd1 : 3'd2);
    return 32'({st, 1'b1, dn, valv[n-1-i], seqv[n-1-i]});
  endfunction

  task automatic run_frame(input string tag, input logic [7:0] pat, input logic [3:0] len,
                           input logic [3:0] rep, input logic [3:0] gp, input int n,
                           input logic [63:0] seqv, input logic [63:0] valv, input bit disturb);
    @(negedge clk_i);
    pattern_i = pat; length_i = len; repeat_cnt_i = rep; gap_i = gp; start_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
    for (int i = 0; i < n; i++) begin
      if (i > 0) @(negedge clk_i);
      check_eq($sformatf("%s[%0d]", tag, i), obs(), exp_vec(i, n, seqv, valv));
      if (disturb && i == 2) begin
        pattern_i = ~pat; length_i = 4'd3; repeat_cnt_i = 4'd5; gap_i = 4'd7; start_i = 1'b1;
      end
      if (disturb && i == 5) start_i = 1'b0;
    end
    @(negedge clk_i);
    check_eq($sformatf("%s_idle", tag), obs(), 32'h0);
  endtask

  initial begin
    reset_i = 1'b0; start_i = 1'b0; pattern_i = 8'h00;
    length_i = 4'd0; repeat_cnt_i = 4'd0; gap_i = 4'd0;
    #1;
    check_eq("reset_state", obs(), 32'h0);
    @(negedge clk_i);
    reset_i = 1'b1;
    @(negedge clk_i);
    check_eq("post_reset_idle", obs(), 32'h0);

    // Single frames
    run_frame("t1_23_len8", 8'h23, 4'd8, 4'd0, 4'd0, 9, 64'b001000110, 64'b111111110, 1'b0);
    run_frame("t2_05_len3", 8'h05, 4'd3, 4'd0, 4'd0, 4, 64'b1010, 64'b1110, 1'b0);
    run_frame("t2_len0",    8'hA5, 4'd0, 4'd0, 4'd0, 9, 64'b101001010, 64'b111111110, 1'b0);
    run_frame("t2_len12",   8'hA5, 4'd12, 4'd0, 4'd0, 9, 64'b101001010, 64'b111111110, 1'b0);
    // Repetitions with and without gaps
    run_frame("t3_rep1_gap2", 8'h0B, 4'd4, 4'd1, 4'd2, 11, 64'b10110010110, 64'b11110011110, 1'b0);
    run_frame("t4_rep1_gap0", 8'h0B, 4'd4, 4'd1, 4'd0, 9, 64'b101110110, 64'b111111110, 1'b0);
    run_frame("rep2_gap1",    8'h02, 4'd2, 4'd2, 4'd1, 9, 64'b100100100, 64'b110110110, 1'b0);
    // Input changes and start pulses mid-frame are ignored
    run_frame("t5_disturb", 8'h23, 4'd8, 4'd0, 4'd0, 9, 64'b001000110, 64'b111111110, 1'b1);

    // Asynchronous reset during the 4th bit
    @(negedge clk_i);
    pattern_i = 8'h23; length_i = 4'd8; repeat_cnt_i = 4'd0; gap_i = 4'd0; start_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
    check_eq("t5r_bit0", obs(), 32'({3'd1, 4'b1010}));
    @(negedge clk_i);
    check_eq("t5r_bit1", obs(), 32'({3'd1, 4'b1010}));
    @(negedge clk_i);
    check_eq("t5r_bit2", obs(), 32'({3'd1, 4'b1011}));
    @(posedge clk_i);
    #1;
    check_eq("t5r_bit3", obs(), 32'({3'd1, 4'b1010}));
    #1;
    reset_i = 1'b0;
    #1;
    check_eq("t5r_async_reset", obs(), 32'h0);
    @(negedge clk_i);
    reset_i = 1'b1;
    @(negedge clk_i);
    check_eq("t5r_stays_idle", obs(), 32'h0);
    run_frame("t5_after_reset", 8'h23, 4'd8, 4'd0, 4'd0, 9, 64'b001000110, 64'b111111110, 1'b0);

    // start held high: 9-cycle frames separated by one idle cycle
    @(negedge clk_i);
    pattern_i = 8'h23; length_i = 4'd8; repeat_cnt_i = 4'd0; gap_i = 4'd0; start_i = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk_i);
      if (i % 10 == 9) begin
        check_eq($sformatf("t6_idle[%0d]", i), obs(), 32'h0);
      end else begin
        check_eq($sformatf("t6[%0d]", i), obs(), exp_vec(i % 10, 9, 64'b001000110, 64'b111111110));
      end
    end
    start_i = 1'b0;
    @(negedge clk_i);
    check_eq("t6_stopped", obs(), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
